// File: rtl/trgg_pkg.sv
// Shared types and sizing helpers for the trigger-link SPI responder.
package trgg_pkg;

  localparam int unsigned TRGG_DW = 16;

  typedef enum logic [1:0] {
    StWaitHi,
    StIdle,
    StShift
  } trgg_state_e;

  // bit_cnt must hold 0..DW+1 so an over-long frame stays distinguishable from a full one.
  function automatic int unsigned trgg_cnt_w(input int unsigned dw);
    return $clog2(dw + 2);
  endfunction

endpackage

// File: rtl/trgg_sync.sv
// Multi-flop synchronizer with history flop; registered level and edge outputs.
module trgg_sync #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[Stages-2:0], pin_i};
    hist_d = sync_q[Stages-1];
    rise_d = sync_q[Stages-1] & ~hist_q;
    fall_d = ~sync_q[Stages-1] & hist_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {Stages{ResetVal}};
      hist_q <= ResetVal;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // history flop carries the same sample instant as the registered edge pulses
  assign level_o = hist_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/trgg_slv.sv
// SPI mode-0 responder for one trigger channel: serves tx_data on MISO, captures MOSI.
module trgg_slv
  import trgg_pkg::*;
#(
  parameter int unsigned DW          = TRGG_DW,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pin_sclk,
  input  logic          pin_cs,
  input  logic          pin_mosi,
  output logic          pin_miso,
  input  logic [DW-1:0] tx_data,
  output logic          tx_ack,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  output logic          frame_err
);

  localparam int unsigned    CntW    = trgg_cnt_w(DW);
  localparam logic [CntW-1:0] CntFull = CntW'(DW);
  localparam logic [CntW-1:0] CntMax  = CntW'(DW + 1);
  localparam logic [CntW-1:0] Flush   = CntW'(SYNC_STAGES + 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  trgg_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_sclk (
    .clk    (clk),
    .rst    (rst),
    .pin_i  (pin_sclk),
    .level_o(sclk_level_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  trgg_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_cs (
    .clk    (clk),
    .rst    (rst),
    .pin_i  (pin_cs),
    .level_o(cs_level),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  trgg_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_mosi (
    .clk    (clk),
    .rst    (rst),
    .pin_i  (pin_mosi),
    .level_o(mosi_level),
    .rise_o (mosi_rise_unused),
    .fall_o (mosi_fall_unused)
  );

  trgg_state_e     state_q, state_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]   tx_sh_q, tx_sh_d;
  logic [DW-1:0]   rx_sh_q, rx_sh_d;
  logic [DW-1:0]   rx_data_q, rx_data_d;
  logic            miso_q, miso_d;
  logic            tx_ack_q, tx_ack_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StWaitHi;
      bit_cnt_q   <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      miso_q      <= 1'b0;
      tx_ack_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      miso_q      <= miso_d;
      tx_ack_q    <= tx_ack_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // The cs synchronizer resets to 1, so WAIT_HI must first flush it before trusting cs_level.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitHi: if (bit_cnt_q == Flush && cs_level) state_d = StIdle;
      StIdle:   if (cs_fall) state_d = StShift;
      StShift:  if (cs_rise) state_d = StIdle;
      default:  state_d = StWaitHi;
    endcase
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    tx_ack_d    = 1'b0;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StWaitHi: begin
        if (bit_cnt_q != Flush) bit_cnt_d = bit_cnt_q + CntOne;
        else if (cs_level)      bit_cnt_d = '0;
      end
      StIdle: begin
        if (cs_fall) begin
          tx_sh_d   = tx_data;
          tx_ack_d  = 1'b1;
          bit_cnt_d = '0;
        end
      end
      StShift: begin
        if (cs_rise) begin
          if (bit_cnt_q == CntFull) begin
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (!cs_level) begin
          if (sclk_rise) begin
            rx_sh_d = {rx_sh_q[DW-2:0], mosi_level};
            if (bit_cnt_q != CntMax) bit_cnt_d = bit_cnt_q + CntOne;
          end
          // zeros shift in, so MISO idles low once all DW bits have gone out
          if (sclk_fall) tx_sh_d = {tx_sh_q[DW-2:0], 1'b0};
        end
      end
      default: ;
    endcase
    miso_d = (state_d == StShift) ? tx_sh_d[DW-1] : 1'b0;
  end

  assign pin_miso  = miso_q;
  assign tx_ack    = tx_ack_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_trgg_slv.sv
// Directed bench for trgg_slv: bench acts as SPI master at sclk = clk/8.
module tb_trgg_slv;

  localparam int DW          = 16;
  localparam int SYNC_STAGES = 2;
  localparam int LAT         = SYNC_STAGES + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          pin_sclk, pin_cs, pin_mosi, pin_miso;
  logic [DW-1:0] tx_data, rx_data;
  logic          tx_ack, rx_valid, frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ack    = 0;
  int n_rxv    = 0;
  int n_err    = 0;

  trgg_slv #(.DW(DW), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk      (clk),
    .rst      (rst),
    .pin_sclk (pin_sclk),
    .pin_cs   (pin_cs),
    .pin_mosi (pin_mosi),
    .pin_miso (pin_miso),
    .tx_data  (tx_data),
    .tx_ack   (tx_ack),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (tx_ack)    n_ack <= n_ack + 1;
    if (rx_valid)  n_rxv <= n_rxv + 1;
    if (frame_err) n_err <= n_err + 1;
  end

  typedef struct {
    logic [15:0] tx;
    logic [15:0] mosi;
    int          nbits;
    logic [31:0] exp_miso;
    logic [15:0] exp_rx;
    int          exp_rxv;
    int          exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  // One sclk period starting at sclk fall: set mosi, rise after 4 clk and sample miso.
  task automatic bit_cycle(input logic mb, output logic mo);
    pin_mosi = mb;
    repeat (4) @(negedge clk);
    pin_sclk = 1'b1;
    mo = pin_miso;
    repeat (4) @(negedge clk);
    pin_sclk = 1'b0;
  endtask

  task automatic spi_frame(input logic [15:0] tx, input logic [15:0] word, input int nbits,
                           output logic [31:0] miso_bits, output int ack_lat,
                           output int end_lat);
    logic mo, mb;
    tx_data = tx;
    @(negedge clk);
    pin_cs  = 1'b0;
    ack_lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (tx_ack && ack_lat == 0) ack_lat = k;
    end
    @(negedge clk);
    tx_data   = ~tx;  // only the value in the tx_ack cycle may be served
    miso_bits = '0;
    for (int i = 0; i < nbits; i++) begin
      mb = (i < DW) ? word[15-i] : 1'b0;
      bit_cycle(mb, mo);
      miso_bits = {miso_bits[30:0], mo};
    end
    repeat (4) @(negedge clk);
    pin_cs  = 1'b1;
    end_lat = 0;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(posedge clk);
      #1;
      if ((rx_valid || frame_err) && end_lat == 0) end_lat = k;
    end
    @(negedge clk);
    repeat (16) @(negedge clk);
  endtask

  task automatic run_vec(input int i);
    logic [31:0] miso_bits;
    int ack_lat, end_lat, a0, r0, e0;
    a0 = n_ack;
    r0 = n_rxv;
    e0 = n_err;
    spi_frame(vecs[i].tx, vecs[i].mosi, vecs[i].nbits, miso_bits, ack_lat, end_lat);
    check($sformatf("v%0d miso", i), miso_bits, vecs[i].exp_miso);
    check($sformatf("v%0d rx_data", i), 32'(rx_data), 32'(vecs[i].exp_rx));
    check($sformatf("v%0d rx_valid_cnt", i), n_rxv - r0, vecs[i].exp_rxv);
    check($sformatf("v%0d frame_err_cnt", i), n_err - e0, vecs[i].exp_err);
    check($sformatf("v%0d tx_ack_cnt", i), n_ack - a0, 1);
    check($sformatf("v%0d tx_ack_lat", i), ack_lat, LAT);
    check($sformatf("v%0d end_lat", i), end_lat, LAT);
  endtask

  initial begin
    logic mo;
    int a0, r0, e0, bad;
    logic [15:0] rx0;

    // sampling edge counts as edge 1 in the latency figures
    vecs[0] = '{16'hA5C3, 16'h1234, 16, 32'h0000_A5C3, 16'h1234, 1, 0};
    vecs[1] = '{16'h0F0F, 16'hBEEF, 16, 32'h0000_0F0F, 16'hBEEF, 1, 0};
    vecs[2] = '{16'h1357, 16'hFFFF, 9,  32'h0000_0026, 16'hBEEF, 0, 1};
    vecs[3] = '{16'hC0DE, 16'h5A5A, 16, 32'h0000_C0DE, 16'h5A5A, 1, 0};
    vecs[4] = '{16'hFFFF, 16'h00FF, 18, 32'h0003_FFFC, 16'h5A5A, 0, 1};
    vecs[5] = '{16'h1111, 16'h0000, 0,  32'h0000_0000, 16'h5A5A, 0, 1};
    vecs[6] = '{16'h0001, 16'h8000, 16, 32'h0000_0001, 16'h8000, 1, 0};

    rst      = 1'b1;
    pin_cs   = 1'b1;
    pin_sclk = 1'b0;
    pin_mosi = 1'b0;
    tx_data  = '0;
    repeat (3) @(negedge clk);
    check("rst pin_miso", 32'(pin_miso), 0);
    check("rst tx_ack", 32'(tx_ack), 0);
    check("rst rx_valid", 32'(rx_valid), 0);
    check("rst frame_err", 32'(frame_err), 0);
    check("rst rx_data", 32'(rx_data), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // cs high with sclk toggling: nothing may move
    a0 = n_ack; r0 = n_rxv; e0 = n_err; rx0 = rx_data; bad = 0;
    for (int t = 0; t < 32; t++) begin
      if (t % 4 == 0) begin
        pin_sclk = ~pin_sclk;
        pin_mosi = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (pin_miso !== 1'b0) bad++;
    end
    pin_sclk = 1'b0;
    repeat (8) @(negedge clk);
    check("idle miso_nonzero", bad, 0);
    check("idle pulses", (n_ack - a0) + (n_rxv - r0) + (n_err - e0), 0);
    check("idle rx_data", 32'(rx_data), 32'(rx0));

    for (int i = 0; i < 6; i++) run_vec(i);

    // reset after 5 bits with cs held low; the tail of the frame must be ignored
    a0 = n_ack; r0 = n_rxv; e0 = n_err;
    tx_data = 16'h7777;
    @(negedge clk);
    pin_cs = 1'b0;
    repeat (12) @(negedge clk);
    for (int b = 0; b < 5; b++) bit_cycle(1'b1, mo);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int b = 0; b < 11; b++) bit_cycle(1'b0, mo);
    repeat (4) @(negedge clk);
    check("midrst rx_data", 32'(rx_data), 0);
    check("midrst miso", 32'(pin_miso), 0);
    pin_cs = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst rx_valid_cnt", n_rxv - r0, 0);
    check("midrst frame_err_cnt", n_err - e0, 0);
    check("midrst tx_ack_cnt", n_ack - a0, 1);

    run_vec(6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
